// File: rtl/encoder_8_bit.sv
// -----------------------------------------------------------------------------
// encoder_8_bit
//   8-to-3 priority encoder. Reduces eight request bits to the binary index
//   of the winning asserted bit plus a valid flag.
//
//   Parameters
//     MSB_PRIORITY  1: highest set index wins; 0: lowest set index wins.
//     REGISTERED    1: out/valid registered (one-cycle latency);
//                   0: out/valid combinational, clk/rst_n unused.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset (clears out/valid)
//     out[2:0]   out  index of the winning asserted input
//     valid      out  1 when any of in0..in7 is asserted
//     in0..in7   in   request bits, in0 lowest index, in7 highest
// -----------------------------------------------------------------------------
module encoder_8_bit #(
    parameter bit MSB_PRIORITY = 1'b1,
    parameter bit REGISTERED   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] out,
    output logic       valid,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic       in7
);

    logic [7:0] req;
    logic [2:0] enc_idx;
    logic       enc_valid;

    assign req = {in7, in6, in5, in4, in3, in2, in1, in0};

    // The scan order decides the winner: the last hit in the loop overrides
    // earlier ones, so MSB priority scans upward and LSB priority scans down.
    always_comb begin
        enc_idx   = 3'd0;
        enc_valid = |req;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) enc_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (req[i]) enc_idx = 3'(i);
            end
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out   <= 3'd0;
                    valid <= 1'b0;
                end else begin
                    out   <= enc_idx;
                    valid <= enc_valid;
                end
            end
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out   = enc_idx;
            assign valid = enc_valid;
        end
    endgenerate

endmodule

// File: tb/tb_encoder_8_bit.sv
module tb_encoder_8_bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic [2:0] out_msb,  out_lsb,  out_comb;
    logic       valid_msb, valid_lsb, valid_comb;

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    encoder_8_bit #(.MSB_PRIORITY(1'b1), .REGISTERED(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .out(out_msb), .valid(valid_msb),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7])
    );

    encoder_8_bit #(.MSB_PRIORITY(1'b0), .REGISTERED(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .out(out_lsb), .valid(valid_lsb),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7])
    );

    encoder_8_bit #(.MSB_PRIORITY(1'b1), .REGISTERED(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .out(out_comb), .valid(valid_comb),
        .in0(req[0]), .in1(req[1]), .in2(req[2]), .in3(req[3]),
        .in4(req[4]), .in5(req[5]), .in6(req[6]), .in7(req[7])
    );

    // Reference model: returns {valid, index}.
    function automatic logic [3:0] ref_enc(input logic [7:0] v, input bit msb);
        logic [7:0] w;
        int         pos;
        if (v == 8'h00) return 4'b0000;
        w   = v;
        pos = 0;
        if (msb) begin
            while (w > 8'h01) begin
                w = w >> 1;
                pos++;
            end
        end else begin
            while (w[0] == 1'b0) begin
                w = w >> 1;
                pos++;
            end
        end
        return {1'b1, 3'(pos)};
    endfunction

    // Present a vector on a falling edge; the following falling edge sits
    // half a cycle after the capturing rising edge.
    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold_msb got valid=%b out=%0d want valid=0 out=0", valid_msb, out_msb);
        end
        n_vec++;
        if ({valid_lsb, out_lsb} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold_lsb got valid=%b out=%0d want valid=0 out=0", valid_lsb, out_lsb);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_release_msb got valid=%b out=%0d want valid=1 out=7", valid_msb, out_msb);
        end
        n_vec++;
        if ({valid_lsb, out_lsb} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_release_lsb got valid=%b out=%0d want valid=1 out=0", valid_lsb, out_lsb);
        end
    endtask

    task automatic test_priority_sweep();
        logic [7:0] vecs [8] = '{8'b11001100, 8'b01100110, 8'b00110011, 8'b00010010,
                                 8'b00001001, 8'b00000100, 8'b00000011, 8'b00000001};
        logic [2:0] exp  [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 8; k++) begin
            apply(vecs[k]);
            n_vec++;
            if ({valid_msb, out_msb} !== {1'b1, exp[k]}) begin
                n_err++;
                $display("FAIL sweep_%b got valid=%b out=%0d want valid=1 out=%0d",
                         vecs[k], valid_msb, out_msb, exp[k]);
            end
        end
    endtask

    task automatic test_empty();
        apply(8'b00000000);
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b0000) begin
            n_err++;
            $display("FAIL empty got valid=%b out=%0d want valid=0 out=0", valid_msb, out_msb);
        end
        apply(8'b00000001);
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b1000) begin
            n_err++;
            $display("FAIL in0_only got valid=%b out=%0d want valid=1 out=0", valid_msb, out_msb);
        end
    endtask

    task automatic test_lsb_mode();
        logic [7:0] vecs [3] = '{8'b11001100, 8'b01100000, 8'b10000000};
        logic [2:0] exp  [3] = '{3'd2, 3'd5, 3'd7};
        for (int k = 0; k < 3; k++) begin
            apply(vecs[k]);
            n_vec++;
            if ({valid_lsb, out_lsb} !== {1'b1, exp[k]}) begin
                n_err++;
                $display("FAIL lsb_%b got valid=%b out=%0d want valid=1 out=%0d",
                         vecs[k], valid_lsb, out_lsb, exp[k]);
            end
        end
    endtask

    task automatic test_latency();
        apply(8'b10000000);
        req = 8'b00000100;
        #2;
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b1111) begin
            n_err++;
            $display("FAIL latency_hold got valid=%b out=%0d want valid=1 out=7", valid_msb, out_msb);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b1010) begin
            n_err++;
            $display("FAIL latency_update got valid=%b out=%0d want valid=1 out=2", valid_msb, out_msb);
        end
    endtask

    task automatic test_async_reset();
        apply(8'b01000000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_msb got valid=%b out=%0d want valid=0 out=0", valid_msb, out_msb);
        end
        n_vec++;
        if ({valid_lsb, out_lsb} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_lsb got valid=%b out=%0d want valid=0 out=0", valid_lsb, out_lsb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({valid_msb, out_msb} !== 4'b1110) begin
            n_err++;
            $display("FAIL async_recover got valid=%b out=%0d want valid=1 out=6", valid_msb, out_msb);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] exp_m;
        logic [3:0] exp_l;
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            req   = 8'(v);
            exp_m = ref_enc(8'(v), 1'b1);
            exp_l = ref_enc(8'(v), 1'b0);
            #1;
            n_vec++;
            if ({valid_comb, out_comb} !== exp_m) begin
                n_err++;
                $display("FAIL comb_%0d got valid=%b out=%0d want valid=%b out=%0d",
                         v, valid_comb, out_comb, exp_m[3], exp_m[2:0]);
            end
            @(negedge clk);
            n_vec++;
            if ({valid_msb, out_msb} !== exp_m) begin
                n_err++;
                $display("FAIL exh_msb_%0d got valid=%b out=%0d want valid=%b out=%0d",
                         v, valid_msb, out_msb, exp_m[3], exp_m[2:0]);
            end
            n_vec++;
            if ({valid_lsb, out_lsb} !== exp_l) begin
                n_err++;
                $display("FAIL exh_lsb_%0d got valid=%b out=%0d want valid=%b out=%0d",
                         v, valid_lsb, out_lsb, exp_l[3], exp_l[2:0]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        test_reset();
        test_priority_sweep();
        test_empty();
        test_lsb_mode();
        test_latency();
        test_async_reset();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
